// File: rtl/mdu_unit_if.sv
// rtl/mdu_unit_if.sv - E-stage multiply/divide unit port bundle (cancel present with MDU_CANCEL_EN)
interface mdu_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_sel;
    logic        busy;
    logic [31:0] md_out;
`ifdef MDU_CANCEL_EN
    logic        cancel;

    modport master (output start, md_op, rs_val, rt_val, rd_sel, cancel, input busy, md_out);
    modport slave  (input start, md_op, rs_val, rt_val, rd_sel, cancel, output busy, md_out);
`else
    modport master (output start, md_op, rs_val, rt_val, rd_sel, input busy, md_out);
    modport slave  (input start, md_op, rs_val, rt_val, rd_sel, output busy, md_out);
`endif
endinterface

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO (optional flush: MDU_CANCEL_EN)
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [31:0]   pending_hi;
    logic [31:0]   pending_lo;
    logic          pending_ok;
    logic [CW-1:0] counter;

    logic [63:0]   calc;
    logic          calc_ok;
    logic          calc_arith;
    logic [CW-1:0] calc_cycles;
    logic [31:0]   safe_rt;
    logic [31:0]   quo;
    logic [31:0]   rem;
    logic          flush;

`ifdef MDU_CANCEL_EN
    assign flush = md.cancel;
`else
    assign flush = 1'b0;
`endif

    assign md.busy   = (counter != '0);
    assign md.md_out = md.rd_sel ? lo : hi;

    // Result of the op presented this cycle; a zero divisor is swapped for 1 so the
    // dividers never see zero, and calc_ok then blocks the commit.
    always_comb begin
        calc        = '0;
        calc_ok     = 1'b1;
        calc_arith  = 1'b0;
        calc_cycles = '0;
        quo         = '0;
        rem         = '0;
        safe_rt     = (md.rt_val == '0) ? 32'd1 : md.rt_val;
        case (md.md_op)
            OP_MULT: begin
                calc_arith  = 1'b1;
                calc_cycles = CW'(MULT_CYCLES);
                calc = $signed({{32{md.rs_val[31]}}, md.rs_val}) *
                       $signed({{32{md.rt_val[31]}}, md.rt_val});
            end
            OP_MULTU: begin
                calc_arith  = 1'b1;
                calc_cycles = CW'(MULT_CYCLES);
                calc = {32'd0, md.rs_val} * {32'd0, md.rt_val};
            end
            OP_DIV: begin
                calc_arith  = 1'b1;
                calc_cycles = CW'(DIV_CYCLES);
                calc_ok     = (md.rt_val != '0);
                if (md.rs_val == 32'h8000_0000 && md.rt_val == 32'hFFFF_FFFF) begin
                    quo = 32'h8000_0000;
                    rem = 32'd0;
                end else begin
                    quo = $signed(md.rs_val) / $signed(safe_rt);
                    rem = $signed(md.rs_val) % $signed(safe_rt);
                end
                calc = {rem, quo};
            end
            OP_DIVU: begin
                calc_arith  = 1'b1;
                calc_cycles = CW'(DIV_CYCLES);
                calc_ok     = (md.rt_val != '0);
                quo  = md.rs_val / safe_rt;
                rem  = md.rs_val % safe_rt;
                calc = {rem, quo};
            end
            default: begin
                calc_arith = 1'b0;
            end
        endcase
    end

    // Launch, count down and commit; starts arriving while busy are dropped outright.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
            pending_ok <= 1'b0;
            counter    <= '0;
        end else if (flush) begin
            counter    <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
            pending_ok <= 1'b0;
        end else if (counter != '0) begin
            counter <= counter - CW'(1);
            if (counter == CW'(1) && pending_ok) begin
                hi <= pending_hi;
                lo <= pending_lo;
            end
        end else if (md.start) begin
            if (calc_arith) begin
                pending_hi <= calc[63:32];
                pending_lo <= calc[31:0];
                pending_ok <= calc_ok;
                counter    <= calc_cycles;
            end else if (md.md_op == OP_MTHI) begin
                hi <= md.rs_val;
            end else if (md.md_op == OP_MTLO) begin
                lo <= md.rs_val;
            end
        end
    end
endmodule
